// File: rtl/trojan_vector_sweeper_if.sv
// Sweeper channel bundle: control, DUT drive/response, record stream and status.
// master = sweeper side, slave = environment (DUT harness, trace writer, controller).
interface trojan_vector_sweeper_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 1,
  parameter int SIG_W = 16
);
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   stim;
  logic              stim_valid;
  logic [N_OUT-1:0]  dut_out;
  logic              rec_valid;
  logic              rec_ready;
  logic [N_IN-1:0]   rec_stim;
  logic [N_OUT-1:0]  rec_resp;
  logic [N_IN:0]     vec_count;
  logic [SIG_W-1:0]  signature;
  logic              done;

  modport master (
    input  start, abort, dut_out, rec_ready,
    output stim, stim_valid, rec_valid, rec_stim, rec_resp, vec_count, signature, done
  );

  modport slave (
    output start, abort, dut_out, rec_ready,
    input  stim, stim_valid, rec_valid, rec_stim, rec_resp, vec_count, signature, done
  );
endinterface

// File: rtl/trojan_vector_sweeper.sv
// Exhaustive input sweeper: drives every N_IN-bit vector, captures the settled response,
// streams (vector, response) records and folds every response into a MISR signature.
module trojan_vector_sweeper #(
  parameter int               N_IN       = 7,
  parameter int               N_OUT      = 1,
  parameter int               SETTLE_CYC = 1,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] SIG_POLY   = 16'h8016
) (
  input logic                    CK,
  input logic                    reset,
  trojan_vector_sweeper_if.master bus
);

  localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE_CYC);
  localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
  localparam logic [N_IN:0] CNT_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_t;

  state_t             state_reg, state_next;
  logic [N_IN-1:0]    stim_reg;
  logic               stim_valid_reg;
  logic [7:0]         settle_cnt_reg;
  logic               rec_valid_reg;
  logic [N_IN-1:0]    rec_stim_reg;
  logic [N_OUT-1:0]   rec_resp_reg;
  logic [N_IN:0]      vec_count_reg;
  logic [SIG_W-1:0]   sig_reg;
  logic               done_reg;

  logic               handshake;
  logic               last_vec;
  logic               do_start, do_count, do_capture, do_advance, do_finish;
  logic [SIG_W-1:0]   sig_next;

  assign handshake = rec_valid_reg && bus.rec_ready;
  assign last_vec  = &stim_reg;
  assign sig_next  = {sig_reg[SIG_W-2:0], 1'b0}
                   ^ (sig_reg[SIG_W-1] ? SIG_POLY : '0)
                   ^ SIG_W'(bus.dut_out);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE, DONE: if (bus.start) state_next = SETTLE;
        SETTLE:     if (settle_cnt_reg == 8'd0) state_next = HOLD;
        HOLD: begin
          if (handshake) state_next = last_vec ? DONE : SETTLE;
        end
      endcase
    end
  end

  // Abort suppresses every action so it wins over start and handshakes alike.
  always_comb begin
    do_start   = 1'b0;
    do_count   = 1'b0;
    do_capture = 1'b0;
    do_advance = 1'b0;
    do_finish  = 1'b0;
    if (!bus.abort) begin
      unique case (state_reg)
        IDLE, DONE: do_start = bus.start;
        SETTLE: begin
          if (settle_cnt_reg == 8'd0) do_capture = 1'b1;
          else                        do_count   = 1'b1;
        end
        HOLD: begin
          if (handshake) begin
            do_finish  = last_vec;
            do_advance = !last_vec;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      stim_reg       <= '0;
      stim_valid_reg <= 1'b0;
      settle_cnt_reg <= 8'd0;
      rec_valid_reg  <= 1'b0;
      rec_stim_reg   <= '0;
      rec_resp_reg   <= '0;
      vec_count_reg  <= '0;
      sig_reg        <= '0;
      done_reg       <= 1'b0;
    end else begin
      if (bus.abort) begin
        rec_valid_reg  <= 1'b0;
        stim_valid_reg <= 1'b0;
        done_reg       <= 1'b0;
      end
      if (do_start) begin
        stim_reg       <= '0;
        stim_valid_reg <= 1'b1;
        settle_cnt_reg <= SETTLE_INIT;
        sig_reg        <= '0;
        vec_count_reg  <= '0;
        done_reg       <= 1'b0;
      end
      if (do_count) settle_cnt_reg <= settle_cnt_reg - 8'd1;
      // The MISR only moves on capture, so a stalled record cannot fold in twice.
      if (do_capture) begin
        rec_stim_reg  <= stim_reg;
        rec_resp_reg  <= bus.dut_out;
        rec_valid_reg <= 1'b1;
        sig_reg       <= sig_next;
      end
      if (do_advance || do_finish) begin
        rec_valid_reg <= 1'b0;
        vec_count_reg <= vec_count_reg + CNT_ONE;
      end
      if (do_advance) begin
        stim_reg       <= stim_reg + STIM_ONE;
        settle_cnt_reg <= SETTLE_INIT;
      end
      if (do_finish) begin
        stim_valid_reg <= 1'b0;
        done_reg       <= 1'b1;
      end
    end
  end

  assign bus.stim       = stim_reg;
  assign bus.stim_valid = stim_valid_reg;
  assign bus.rec_valid  = rec_valid_reg;
  assign bus.rec_stim   = rec_stim_reg;
  assign bus.rec_resp   = rec_resp_reg;
  assign bus.vec_count  = vec_count_reg;
  assign bus.signature  = sig_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_trojan_vector_sweeper.sv
// Directed bench for trojan_vector_sweeper: a 7-bit sweep with parity DUT plus two 3-bit
// sweepers (settle 0 and 3) driving a DUT modelled as two register stages.
module tb_trojan_vector_sweeper;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  trojan_vector_sweeper_if #(.N_IN(7), .N_OUT(1), .SIG_W(16)) b7 ();
  trojan_vector_sweeper_if #(.N_IN(3), .N_OUT(3), .SIG_W(16)) ba ();
  trojan_vector_sweeper_if #(.N_IN(3), .N_OUT(3), .SIG_W(16)) bb ();

  trojan_vector_sweeper #(.N_IN(7), .N_OUT(1), .SETTLE_CYC(1), .SIG_W(16), .SIG_POLY(16'h8016))
    u7 (.CK(clk), .reset(reset), .bus(b7));
  trojan_vector_sweeper #(.N_IN(3), .N_OUT(3), .SETTLE_CYC(0), .SIG_W(16), .SIG_POLY(16'h8016))
    ua (.CK(clk), .reset(reset), .bus(ba));
  trojan_vector_sweeper #(.N_IN(3), .N_OUT(3), .SETTLE_CYC(3), .SIG_W(16), .SIG_POLY(16'h8016))
    ub (.CK(clk), .reset(reset), .bus(bb));

  // DUT models: parity for the wide sweeper; selectable zero / stim[0] / two-register pipe for the small ones.
  int small_mode = 0;
  logic [2:0] da1 = 3'd0, da2 = 3'd0, db1 = 3'd0, db2 = 3'd0;
  always @(posedge clk) begin
    da1 <= ba.stim; da2 <= da1;
    db1 <= bb.stim; db2 <= db1;
  end
  assign b7.dut_out = ^b7.stim;
  assign ba.dut_out = (small_mode == 2) ? da2 : (small_mode == 1) ? {2'b00, ba.stim[0]} : 3'd0;
  assign bb.dut_out = (small_mode == 2) ? db2 : (small_mode == 1) ? {2'b00, bb.stim[0]} : 3'd0;

  int checks = 0;
  int failures = 0;

  // Record monitors: a transfer completes on the next edge when valid&&ready (and no abort).
  logic [6:0] q_stim[$];
  logic       q_resp[$];
  logic [2:0] cap_a[8];
  logic [2:0] cap_b[8];
  always @(negedge clk) begin
    if (reset && b7.rec_valid && b7.rec_ready && !b7.abort) begin
      q_stim.push_back(b7.rec_stim);
      q_resp.push_back(b7.rec_resp[0]);
    end
    if (reset && ba.rec_valid && ba.rec_ready) cap_a[ba.rec_stim] <= ba.rec_resp;
    if (reset && bb.rec_valid && bb.rec_ready) cap_b[bb.rec_stim] <= bb.rec_resp;
  end

  typedef struct {
    int inst;   // 0 = settle 0, 1 = settle 3
    int stim;
    int resp;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h8016 : 16'h0000) ^ d;
  endfunction

  function automatic logic [15:0] parity_sig(input int last);
    logic [15:0] s = 16'h0000;
    logic [6:0]  vv;
    for (int v = 0; v <= last; v++) begin
      vv = 7'(v);
      s = misr(s, {15'd0, ^vv});
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse7(input logic s, input logic a);
    b7.start = s; b7.abort = a;
    @(posedge clk); #1;
    b7.start = 1'b0; b7.abort = 1'b0;
  endtask

  task automatic wait_rec7(input int s, input int budget, input string name);
    int n = 0;
    while (!(b7.rec_valid && b7.rec_stim == 7'(s)) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(b7.rec_valid && b7.rec_stim == 7'(s)), 32'd1);
  endtask

  task automatic wait_done7(input int budget, output int n);
    n = 0;
    while (!b7.done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_small(input int budget, input string name);
    int n = 0;
    bb.start = 1'b1;
    @(posedge clk); #1;
    bb.start = 1'b0;
    while (!bb.done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(bb.done), 32'd1);
  endtask

  task automatic check_records(input string name, input int n_exp);
    int errs = 0;
    logic [6:0] vv;
    if (q_stim.size() != n_exp) errs++;
    for (int i = 0; i < q_stim.size(); i++) begin
      vv = 7'(i);
      if (q_stim[i] !== vv || q_resp[i] !== ^vv) errs++;
    end
    chk(name, 32'(errs), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stim"},       32'(b7.stim), 32'd0);
    chk({tag, "_stim_valid"}, 32'(b7.stim_valid), 32'd0);
    chk({tag, "_rec_valid"},  32'(b7.rec_valid), 32'd0);
    chk({tag, "_rec_stim"},   32'(b7.rec_stim), 32'd0);
    chk({tag, "_rec_resp"},   32'(b7.rec_resp), 32'd0);
    chk({tag, "_vec_count"},  32'(b7.vec_count), 32'd0);
    chk({tag, "_signature"},  32'(b7.signature), 32'd0);
    chk({tag, "_done"},       32'(b7.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic [15:0] sig_run1;
    logic        hold_resp;

    // Settle-time vectors, responses hand-derived from the two-register DUT pipe.
    tbl[0]  = '{0, 0, 0}; tbl[1]  = '{0, 1, 0}; tbl[2]  = '{0, 2, 1}; tbl[3]  = '{0, 3, 2};
    tbl[4]  = '{0, 4, 3}; tbl[5]  = '{0, 5, 4}; tbl[6]  = '{0, 6, 5}; tbl[7]  = '{0, 7, 6};
    tbl[8]  = '{1, 0, 0}; tbl[9]  = '{1, 1, 1}; tbl[10] = '{1, 2, 2}; tbl[11] = '{1, 3, 3};
    tbl[12] = '{1, 4, 4}; tbl[13] = '{1, 5, 5}; tbl[14] = '{1, 6, 6}; tbl[15] = '{1, 7, 7};

    b7.start = 0; b7.abort = 0; b7.rec_ready = 1;
    ba.start = 0; ba.abort = 0; ba.rec_ready = 1;
    bb.start = 0; bb.abort = 0; bb.rec_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Run 1: full sweep, rec_ready tied high.
    q_stim.delete(); q_resp.delete();
    pulse7(1'b1, 1'b0);
    chk("t1_stim_valid", 32'(b7.stim_valid), 32'd1);
    wait_done7(1000, n);
    chk("t1_done_latency", 32'(n), 32'd384);
    chk("t1_vec_count", 32'(b7.vec_count), 32'd128);
    chk("t1_stim_valid_end", 32'(b7.stim_valid), 32'd0);
    chk("t1_signature", 32'(b7.signature), 32'(parity_sig(127)));
    check_records("t1_records", 128);
    sig_run1 = b7.signature;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_done_held", 32'(b7.done), 32'd1);

    // Run 2: stall record 10 for five cycles.
    q_stim.delete(); q_resp.delete();
    pulse7(1'b1, 1'b0);
    chk("t2_done_cleared", 32'(b7.done), 32'd0);
    wait_rec7(10, 100, "t2_reach_rec10");
    b7.rec_ready = 1'b0;
    hold_resp = b7.rec_resp[0];
    errs = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!b7.rec_valid || b7.rec_stim !== 7'd10 || b7.rec_resp[0] !== hold_resp) errs++;
    end
    chk("t2_hold_stable", 32'(errs), 32'd0);
    chk("t2_resp_rec10", 32'(hold_resp), 32'd0);
    chk("t2_vc_during_stall", 32'(b7.vec_count), 32'd10);
    b7.rec_ready = 1'b1;
    wait_done7(1000, n);
    chk("t2_done", 32'(b7.done), 32'd1);
    chk("t2_signature", 32'(b7.signature), 32'(sig_run1));
    chk("t2_vec_count", 32'(b7.vec_count), 32'd128);
    check_records("t2_records", 128);

    // Run 3: small sweep, zero response, then stim[0] against hand-computed MISR.
    small_mode = 0;
    run_small(200, "t3_zero_done");
    chk("t3_zero_signature", 32'(bb.signature), 32'd0);
    chk("t3_zero_vec_count", 32'(bb.vec_count), 32'd8);
    small_mode = 1;
    run_small(200, "t3_lsb_done");
    chk("t3_lsb_signature", 32'(bb.signature), 32'h0055);
    chk("t3_lsb_vec_count", 32'(bb.vec_count), 32'd8);

    // Run 4: asynchronous reset while record 5 is held.
    q_stim.delete(); q_resp.delete();
    pulse7(1'b1, 1'b0);
    wait_rec7(5, 100, "t4_reach_rec5");
    chk("t4_vc_in_hold", 32'(b7.vec_count), 32'd5);
    reset = 1'b0;
    #1;
    check_all_zero("t4_async");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    pulse7(1'b1, 1'b0);
    chk("t4_restart_stim", 32'(b7.stim), 32'd0);
    chk("t4_restart_valid", 32'(b7.stim_valid), 32'd1);
    wait_rec7(0, 10, "t4_first_rec");
    chk("t4_first_resp", 32'(b7.rec_resp), 32'd0);

    // start mid-sweep is ignored (handshake on the same edge still advances).
    wait_rec7(20, 200, "t4_reach_rec20");
    pulse7(1'b1, 1'b0);
    chk("t4_midstart_vc", 32'(b7.vec_count), 32'd21);
    chk("t4_midstart_stim", 32'(b7.stim), 32'd21);

    // Run 5: abort together with start while record 40 is held.
    wait_rec7(40, 200, "t5_reach_rec40");
    chk("t5_vc_before", 32'(b7.vec_count), 32'd40);
    pulse7(1'b1, 1'b1);
    chk("t5_rec_valid", 32'(b7.rec_valid), 32'd0);
    chk("t5_stim_valid", 32'(b7.stim_valid), 32'd0);
    chk("t5_done", 32'(b7.done), 32'd0);
    chk("t5_vec_count", 32'(b7.vec_count), 32'd40);
    chk("t5_signature", 32'(b7.signature), 32'(parity_sig(40)));
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_restart", 32'(b7.stim_valid), 32'd0);
    chk("t5_rec_idle", 32'(b7.rec_valid), 32'd0);
    chk("t5_vc_kept", 32'(b7.vec_count), 32'd40);

    // Run 6: settle 0 vs 3 against a two-register DUT.
    small_mode = 2;
    ba.start = 1'b1; bb.start = 1'b1;
    @(posedge clk); #1;
    ba.start = 1'b0; bb.start = 1'b0;
    n = 0;
    while (!(ba.done && bb.done) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_both_done", 32'(ba.done && bb.done), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6_settle%0d_stim%0d", tbl[i].inst * 3, tbl[i].stim),
          32'(tbl[i].inst == 0 ? cap_a[tbl[i].stim] : cap_b[tbl[i].stim]),
          32'(tbl[i].resp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
